// File: rtl/mem_stage_access_ctrl.sv
// mem_stage_access_ctrl: MEM-stage data RAM access controller with MEM/WB register
//
// Serves the load/store carried by EX/MEM through a registered req/ack handshake
// to the data RAM, stalling the upstream pipeline while the access is outstanding.
// All state changes on the falling edge of clk, in step with the pipeline registers.
//
// Ports:
//   clk, reset               falling-edge clock, asynchronous active-high reset
//   mem_read_in/write_in     load/store request from EX/MEM (write wins if both)
//   addr_in, wdata_in        effective address / store data from EX/MEM
//   wb_addr_in, reg_write_in,
//   mem_to_reg_in            writeback controls from EX/MEM
//   stall_out                freeze PC/IF/ID/EX/EX-MEM while high (combinational)
//   ram_req/we/addr/wdata    registered RAM request
//   ram_rdata, ram_ack       RAM read data and completion
//   rdata_out, alu_result_out, wb_addr_out,
//   reg_write_out, mem_to_reg_out   MEM/WB register
//   misaligned_err, timeout_err     one-cycle error pulses
module mem_stage_access_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic [4:0]  wb_addr_in,
    input  logic        reg_write_in,
    input  logic        mem_to_reg_in,
    output logic        stall_out,
    output logic        ram_req,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ack,
    output logic [31:0] rdata_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  wb_addr_out,
    output logic        reg_write_out,
    output logic        mem_to_reg_out,
    output logic        misaligned_err,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [31:0] r_rdata_buf;
    logic        r_abort;
    logic        w_mem_op;
    logic        w_issue;
    logic        w_expire;

    assign w_mem_op = mem_read_in | mem_write_in;
    assign w_issue  = w_mem_op & (addr_in[1:0] == 2'b00);
    assign w_expire = r_cnt == 8'(TIMEOUT - 1);

    // Gated by reset so the pipeline is released the moment reset asserts,
    // even though EX/MEM may still present a memory op.
    assign stall_out = ~reset & ((r_state == IDLE & w_issue) | r_state == WAIT);

    always_ff @(negedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Ack is checked before the timeout so a late ack on the final edge still completes.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_issue ? WAIT : IDLE;
            WAIT:    w_next = (ram_ack | w_expire) ? DONE : WAIT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            ram_req        <= 1'b0;
            ram_we         <= 1'b0;
            ram_addr       <= '0;
            ram_wdata      <= '0;
            rdata_out      <= '0;
            alu_result_out <= '0;
            wb_addr_out    <= '0;
            reg_write_out  <= 1'b0;
            mem_to_reg_out <= 1'b0;
            misaligned_err <= 1'b0;
            timeout_err    <= 1'b0;
            r_cnt          <= '0;
            r_rdata_buf    <= '0;
            r_abort        <= 1'b0;
        end else begin
            misaligned_err <= 1'b0;
            timeout_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        ram_req   <= 1'b1;
                        ram_we    <= mem_write_in;
                        ram_addr  <= addr_in;
                        ram_wdata <= wdata_in;
                        r_cnt     <= '0;
                    end else begin
                        // Plain pass-through, or a misaligned access dropped without
                        // touching the RAM and without letting it write a register.
                        alu_result_out <= addr_in;
                        wb_addr_out    <= wb_addr_in;
                        reg_write_out  <= reg_write_in & ~w_mem_op;
                        mem_to_reg_out <= mem_to_reg_in;
                        rdata_out      <= '0;
                        misaligned_err <= w_mem_op;
                    end
                end
                WAIT: begin
                    if (ram_ack) begin
                        ram_req     <= 1'b0;
                        r_rdata_buf <= ram_we ? 32'd0 : ram_rdata;
                    end else if (w_expire) begin
                        ram_req     <= 1'b0;
                        r_rdata_buf <= '0;
                        r_abort     <= 1'b1;
                        timeout_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    // EX/MEM still presents the completed instruction; retire it.
                    alu_result_out <= addr_in;
                    wb_addr_out    <= wb_addr_in;
                    reg_write_out  <= reg_write_in & ~r_abort;
                    mem_to_reg_out <= mem_to_reg_in;
                    rdata_out      <= r_rdata_buf;
                    r_abort        <= 1'b0;
                end
            endcase
        end
    end
endmodule
